// File: rtl/user_mgr_arb.sv
// Round-robin arbiter sharing one OBI manager port among NumMgr user managers,
// with an in-order ID FIFO for response routing. Macro USER_MGR_ARB_FIXED_PRIO_EN selects fixed priority.
package user_mgr_arb_pkg;
  typedef struct packed {
    int unsigned AddrWidth;
    int unsigned DataWidth;
  } obi_cfg_t;

  localparam obi_cfg_t MgrObiCfg = '{AddrWidth: 32, DataWidth: 32};

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } mgr_obi_a_chan_t;

  typedef struct packed {
    mgr_obi_a_chan_t a;
    logic            req;
  } mgr_obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } mgr_obi_r_chan_t;

  typedef struct packed {
    logic            gnt;
    logic            rvalid;
    mgr_obi_r_chan_t r;
  } mgr_obi_rsp_t;
endpackage

// Handshakes: a request transfers when req & gnt are both high in the same cycle;
// a response transfers when rvalid is high (no ready on the r channel).
module user_mgr_arb #(
  parameter int unsigned               NumMgr      = 2,
  parameter user_mgr_arb_pkg::obi_cfg_t ObiCfg     = user_mgr_arb_pkg::MgrObiCfg,
  parameter type                       obi_req_t   = user_mgr_arb_pkg::mgr_obi_req_t,
  parameter type                       obi_rsp_t   = user_mgr_arb_pkg::mgr_obi_rsp_t,
  parameter int unsigned               NumMaxTrans = 2
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  obi_req_t mgr_req_i [NumMgr],
  output obi_rsp_t mgr_rsp_o [NumMgr],
  output obi_req_t arb_req_o,
  input  obi_rsp_t arb_rsp_i
);
  localparam int unsigned IdxW = (NumMgr > 1) ? $clog2(NumMgr) : 1;
  localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
  localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

  logic            r_locked;
  logic [IdxW-1:0] r_lock_idx;
  logic [IdxW-1:0] r_fifo_q [NumMaxTrans];
  logic [CntW-1:0] r_cnt;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW-1:0] r_wr_ptr;

  logic [NumMgr-1:0] w_reqs;
  logic [IdxW-1:0]   w_base;
  logic [IdxW-1:0]   w_sel;
  logic [IdxW-1:0]   w_cand;
  logic [IdxW-1:0]   w_head;
  logic              w_any;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic              w_fwd_req;
  logic              w_hs;
  logic              w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(NumMaxTrans - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef USER_MGR_ARB_FIXED_PRIO_EN
  assign w_base = '0;
`else
  logic [IdxW-1:0] r_rr_ptr;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rr_ptr <= '0;
    end else if (w_hs) begin
      r_rr_ptr <= (w_sel == IdxW'(NumMgr - 1)) ? '0 : w_sel + 1'b1;
    end
  end

  assign w_base = r_rr_ptr;
`endif

  always_comb begin
    w_reqs = '0;
    for (int i = 0; i < int'(NumMgr); i++) w_reqs[i] = mgr_req_i[i].req;
  end

  // Downward scan so the last hit is the first requester at or after w_base.
  always_comb begin
    w_sel  = w_base;
    w_cand = '0;
    if (r_locked) begin
      w_sel = r_lock_idx;
    end else begin
      for (int k = int'(NumMgr) - 1; k >= 0; k--) begin
        w_cand = IdxW'((int'(w_base) + k) % int'(NumMgr));
        if (w_reqs[w_cand]) w_sel = w_cand;
      end
    end
  end

  assign w_any        = |w_reqs;
  assign w_fifo_full  = (r_cnt == CntW'(NumMaxTrans));
  assign w_fifo_empty = (r_cnt == '0);
  assign w_fwd_req    = w_any & mgr_req_i[w_sel].req & ~w_fifo_full;
  assign w_hs         = w_fwd_req & arb_rsp_i.gnt;
  assign w_pop        = arb_rsp_i.rvalid & ~w_fifo_empty;
  assign w_head       = r_fifo_q[r_rd_ptr];

  always_comb begin
    arb_req_o = '0;
    if (rst_ni && w_any) begin
      arb_req_o.a   = mgr_req_i[w_sel].a;
      arb_req_o.req = w_fwd_req;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NumMgr); i++) begin
      mgr_rsp_o[i] = '0;
      if (rst_ni) begin
        mgr_rsp_o[i].r      = arb_rsp_i.r;
        mgr_rsp_o[i].gnt    = w_hs & (w_sel == IdxW'(i));
        mgr_rsp_o[i].rvalid = w_pop & (w_head == IdxW'(i));
      end
    end
  end

  // A forwarded but ungranted request pins the selection until it is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_locked   <= 1'b0;
      r_lock_idx <= '0;
    end else if (w_hs) begin
      r_locked <= 1'b0;
    end else if (w_fwd_req) begin
      r_locked   <= 1'b1;
      r_lock_idx <= w_sel;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(NumMaxTrans); i++) r_fifo_q[i] <= '0;
      r_cnt    <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_hs) begin
        r_fifo_q[r_wr_ptr] <= w_sel;
        r_wr_ptr           <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_hs, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  a_rvalid_owner: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(arb_rsp_i.rvalid && w_fifo_empty))
    else $warning("user_mgr_arb: rvalid with no outstanding transaction, ignored");

  a_data_width: assert property (@(posedge clk_i)
    32'($bits(arb_rsp_i.r.rdata)) == ObiCfg.DataWidth);
endmodule

// File: tb/tb_user_mgr_arb.sv
// Randomized and directed scoreboard bench for user_mgr_arb (default round-robin build).
module tb_user_mgr_arb;
  import user_mgr_arb_pkg::*;

  localparam int NUM_MGR   = 2;
  localparam int MAX_TRANS = 2;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  mgr_obi_req_t mgr_req_i [NUM_MGR];
  mgr_obi_rsp_t mgr_rsp_o [NUM_MGR];
  mgr_obi_req_t arb_req_o;
  mgr_obi_rsp_t arb_rsp_i;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard queues: per-cycle request view, grants, responses.
  logic [32:0] exp_req_q[$];
  logic [32:0] exp_gnt_q[$];
  logic [33:0] exp_rsp_q[$];

  // Reference model state.
  int                 own_q[$];
  int                 rr        = 0;
  int                 committed = -1;
  logic [NUM_MGR-1:0] m_req     = '0;
  logic [31:0]        m_addr [NUM_MGR];
  logic [31:0]        rd_next   = 32'h1000_0000;

  always #5 clk = ~clk;

  user_mgr_arb #(
    .NumMgr      (NUM_MGR),
    .NumMaxTrans (MAX_TRANS)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .mgr_req_i (mgr_req_i),
    .mgr_rsp_o (mgr_rsp_o),
    .arb_req_o (arb_req_o),
    .arb_rsp_i (arb_rsp_i)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic report_extra(input string name, input logic [63:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h expected no event", name, act);
  endtask

  // One bus cycle: managers raise/hold requests, subordinate drives gnt/rvalid,
  // and the model predicts what the arbiter must show this cycle.
  task automatic drive_cycle(input logic [NUM_MGR-1:0] want, input logic gnt,
                             input logic rv, input logic er, input logic stray);
    int   win;
    int   owner;
    logic any;
    logic full;
    logic pres;
    logic rv_eff;
    @(posedge clk);
    #1;
    for (int i = 0; i < NUM_MGR; i++) begin
      if (!m_req[i] && want[i]) begin
        m_req[i]  = 1'b1;
        m_addr[i] = $urandom() & 32'hFFFF_FFFC;
      end
    end
    rv_eff = rv && (own_q.size() > 0 || stray);
    for (int i = 0; i < NUM_MGR; i++) begin
      mgr_req_i[i]         = '0;
      mgr_req_i[i].req     = m_req[i];
      mgr_req_i[i].a.addr  = m_addr[i];
      mgr_req_i[i].a.be    = 4'hF;
      mgr_req_i[i].a.wdata = ~m_addr[i];
    end
    arb_rsp_i        = '0;
    arb_rsp_i.gnt    = gnt;
    arb_rsp_i.rvalid = rv_eff;
    arb_rsp_i.r.rdata = rd_next;
    arb_rsp_i.r.err   = er;

    any = |m_req;
    win = -1;
    if (committed >= 0) win = committed;
    else begin
      for (int k = 0; k < NUM_MGR; k++) begin
        int c;
        c = (rr + k) % NUM_MGR;
        if (win < 0 && m_req[c]) win = c;
      end
    end
    full = (own_q.size() == MAX_TRANS);
    pres = (win >= 0) && m_req[win] && !full;
    if (any) exp_req_q.push_back({pres, m_addr[win]});
    else     exp_req_q.push_back(33'd0);

    if (rv_eff && own_q.size() > 0) begin
      owner = own_q.pop_front();
      exp_rsp_q.push_back({1'(owner), rd_next, er});
    end
    if (rv_eff) rd_next = rd_next + 32'd4;

    if (pres && gnt) begin
      exp_gnt_q.push_back({1'(win), m_addr[win]});
      own_q.push_back(win);
      rr        = (win + 1) % NUM_MGR;
      committed = -1;
      m_req[win] = 1'b0;
    end else if (pres) begin
      committed = win;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 8; n++) drive_cycle('0, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic reset_checks();
    chk("rst_arb_req", 64'({arb_req_o.req, arb_req_o.a.addr, arb_req_o.a.wdata}), 64'd0);
    for (int i = 0; i < NUM_MGR; i++)
      chk("rst_mgr_rsp", 64'({mgr_rsp_o[i].gnt, mgr_rsp_o[i].rvalid,
                              mgr_rsp_o[i].r.rdata, mgr_rsp_o[i].r.err}), 64'd0);
  endtask

  // Drive busy-looking inputs so the all-zero output checks are meaningful.
  task automatic stress_inputs();
    for (int i = 0; i < NUM_MGR; i++) begin
      mgr_req_i[i]        = '0;
      mgr_req_i[i].req    = 1'b1;
      mgr_req_i[i].a.addr = 32'hA000_0000 + 32'(i * 16);
    end
    arb_rsp_i         = '0;
    arb_rsp_i.gnt     = 1'b1;
    arb_rsp_i.rvalid  = 1'b1;
    arb_rsp_i.r.rdata = 32'hDEAD_BEEF;
    arb_rsp_i.r.err   = 1'b1;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #2;
    for (int i = 0; i < NUM_MGR; i++) mgr_req_i[i] = '0;
    arb_rsp_i = '0;
    own_q.delete();
    rr        = 0;
    committed = -1;
    m_req     = '0;
    rst_ni    = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_ni = 1'b0;
    stress_inputs();
    #1;
    reset_checks();
    release_reset();
  endtask

  always @(negedge clk) begin
    if (rst_ni) begin
      if (exp_req_q.size() == 0) report_extra("arb_req_extra", 64'({arb_req_o.req, arb_req_o.a.addr}));
      else chk("arb_req", 64'({arb_req_o.req, arb_req_o.a.addr}), 64'(exp_req_q.pop_front()));
      for (int i = 0; i < NUM_MGR; i++) begin
        if (mgr_rsp_o[i].gnt) begin
          if (exp_gnt_q.size() == 0) report_extra("gnt_extra", 64'({1'(i), arb_req_o.a.addr}));
          else chk("gnt", 64'({1'(i), arb_req_o.a.addr}), 64'(exp_gnt_q.pop_front()));
        end
        if (mgr_rsp_o[i].rvalid) begin
          if (exp_rsp_q.size() == 0)
            report_extra("rsp_extra", 64'({1'(i), mgr_rsp_o[i].r.rdata, mgr_rsp_o[i].r.err}));
          else
            chk("rsp", 64'({1'(i), mgr_rsp_o[i].r.rdata, mgr_rsp_o[i].r.err}),
                64'(exp_rsp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    logic [1:0] w;
    logic       g;
    logic       v;
    logic       e;
    for (int i = 0; i < NUM_MGR; i++) m_addr[i] = '0;
    stress_inputs();
    #3;
    reset_checks();
    release_reset();

    // Idle
    for (int n = 0; n < 3; n++) drive_cycle('0, 1'b1, 1'b0, 1'b0, 1'b0);

    // Continuous requests, gnt tied high, responses one cycle later
    for (int n = 0; n < 8; n++) drive_cycle(2'b11, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // Manager 1 held off for three cycles while manager 0 joins
    drive_cycle(2'b10, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Fill the ID FIFO, then release one slot
    for (int n = 0; n < 4; n++) drive_cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    // Error response for manager 1
    drive_cycle(2'b10, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b00, 1'b0, 1'b1, 1'b1, 1'b0);
    drain();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      w = 2'($urandom_range(0, 3));
      g = ($urandom_range(0, 3) != 0);
      v = ($urandom_range(0, 2) != 0);
      e = 1'($urandom_range(0, 1));
      drive_cycle(w, g, v, e, 1'b0);
    end
    drain();

    // Reset with two outstanding transactions, then a stray response
    drive_cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle(2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    drive_cycle('0, 1'b0, 1'b1, 1'b1, 1'b1);
    drive_cycle(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    drive_cycle('0, 1'b0, 1'b1, 1'b0, 1'b0);
    drain();

    @(negedge clk);
    #1;
    chk("req_q_left", 64'(exp_req_q.size()), 64'd0);
    chk("gnt_q_left", 64'(exp_gnt_q.size()), 64'd0);
    chk("rsp_q_left", 64'(exp_rsp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/user_mgr_arb.md
# user_mgr_arb

Round-robin arbiter that shares the single user-domain OBI manager port (toward the Croc subordinate crossbar) between `NumMgr` user managers. It forwards one request at a time and holds the selection stable until granted. It records the owner of every accepted transaction in an in-order ID FIFO, so each response returns to the manager that issued it. It sits in `user_domain` between the user managers and `user_mgr_obi_req_o`/`user_mgr_obi_rsp_i`.

## Interface
- `NumMgr`, default 2: number of requesting managers, ≥1.
- `ObiCfg`, default `MgrObiCfg`: OBI configuration of all ports.
- `obi_req_t`, default `mgr_obi_req_t`: request struct type.
- `obi_rsp_t`, default `mgr_obi_rsp_t`: response struct type.
- `NumMaxTrans`, default 2: maximum outstanding accepted transactions (ID FIFO depth), ≥1.
- `clk_i`  in  1  clock, single clock domain.
- `rst_ni`  in  1  asynchronous active-low reset.
- `mgr_req_i`  in  `[NumMgr]` × `obi_req_t`  requests from user managers.
- `mgr_rsp_o`  out  `[NumMgr]` × `obi_rsp_t`  responses to user managers.
- `arb_req_o`  out  `obi_req_t`  shared request toward the Croc subordinate.
- `arb_rsp_i`  in  `obi_rsp_t`  shared response from the Croc subordinate.

## Operation
- **State registers**
  - `rr_ptr` (`idx_width(NumMgr)` bits).
  - `locked`, 1 bit.
  - `lock_idx`.
  - ID FIFO: `NumMaxTrans` entries of manager index, with count/rd/wr pointers.
- **Selection, `locked`=0**
  - First requesting manager at or after `rr_ptr`, searching upward with wrap-around modulo `NumMgr`.
- **Selection, `locked`=1**
  - `lock_idx` is selected regardless of other requests.
- **Forwarding**
  - `arb_req_o` carries the selected manager's `a` channel.
  - `arb_req_o.req` = `mgr_req_i[sel].req` AND NOT `fifo_full`.
  - `arb_req_o` is all-zero when no manager requests.
- **Grant**
  - `mgr_rsp_o[sel].gnt` = `arb_rsp_i.gnt` AND `arb_req_o.req`.
  - All other managers see `gnt`=0.
- **Lock**
  - Set `locked`=1, `lock_idx`=`sel` when `arb_req_o.req`=1 and `gnt`=0.
  - Clear on handshake (`req` & `gnt`).
  - This keeps the OBI a-channel stable until grant.
- **On handshake**
  - `rr_ptr` ← (`sel`+1) mod `NumMgr`.
  - Push `sel` into the ID FIFO.
- **Response routing**
  - The `r` channel of `arb_rsp_i` is broadcast to every `mgr_rsp_o[i].r`.
  - `mgr_rsp_o[i].rvalid` = `arb_rsp_i.rvalid` AND (FIFO head == i) AND NOT `fifo_empty`.
  - Pop the FIFO on `arb_rsp_i.rvalid`.
- **Full FIFO**
  - `arb_req_o.req` is held 0 while full, even if a pop occurs in the same cycle.
  - `locked` keeps its value.
- **Simultaneous push and pop when not full**
  - Count is unchanged; both pointers advance.
- **Empty FIFO with `rvalid`**
  - Protocol violation.
  - Ignored: no pop, no `rvalid` forwarded.
  - Flagged by a simulation assertion.
- **Single manager (`NumMgr`=1)**
  - Selection is always 0.
  - `rr_ptr` is a constant 0.
- **Reset values**
  - All outputs are 0, including `arb_req_o` and every `mgr_rsp_o`.
  - `rr_ptr`=0, `locked`=0, FIFO empty.
  - Reset asserted mid-transaction discards outstanding IDs; responses arriving after reset are treated as violations.

## Timing
- The request path (`mgr_req_i` → `arb_req_o`) and the grant path (`arb_rsp_i.gnt` → `mgr_rsp_o.gnt`) are combinational, with zero added latency.
- The response path (`rvalid`, `rdata`, `err`) is combinational through the FIFO head, with zero added latency.
- Arbitration state updates on the rising `clk_i` edge after a handshake. A new winner can be granted in the very next cycle.
- Throughput: one handshake per cycle while the FIFO is not full.
- Fairness: under continuous requests from all managers, each is granted once per `NumMgr` consecutive handshakes.

## Configuration
- Macro: `USER_MGR_ARB_FIXED_PRIO_EN`.
- Defined: fixed priority.
  - The lowest requesting index wins when unlocked.
  - `rr_ptr` is not implemented.
  - The lock rule still applies.
- Undefined (default): round-robin as described under Operation.

## Test plan
- Reset, then idle: all `mgr_req_i.req`=0 → `arb_req_o.req`=0, all `gnt`/`rvalid`=0, FIFO empty.
- Managers 0 and 1 request continuously, `gnt` tied 1, one-cycle `rvalid` → grants alternate 0,1,0,1. Each `rdata` (e.g. `32'h1000_0000` then `32'h1000_0004`) reaches the correct manager.
- Manager 1 requests with `gnt` held 0 for 3 cycles while manager 0 starts requesting → `arb_req_o` stays on manager 1's address throughout. Manager 0 is granted on the cycle after manager 1's handshake.
- `NumMaxTrans`=2 with `rvalid` withheld → two handshakes accepted, then `arb_req_o.req`=0. After one `rvalid`, the next request is forwarded in the following cycle.
- `rvalid` with `err`=1 for a transaction from manager 1 → only `mgr_rsp_o[1].rvalid`=1, and `err`=1 is visible there.
- Reset asserted with 2 outstanding transactions → FIFO empty and outputs 0 immediately. A subsequent stray `rvalid` fires the assertion and is not forwarded.
